// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: fetch-side program counter controller.
// Issues instruction fetches, follows EX-stage branch/jump redirects and
// flushes the instruction sitting in decode whenever a redirect is applied.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | one quiet cycle after reset; no request issued
// S_FETCH | free to issue a fetch at pc, or apply a redirect immediately
// S_WAIT  | fetch at pc outstanding; request held until imem_ready
//
// A redirect that arrives while a fetch is outstanding cannot abandon the
// memory transaction, so its target is parked in a pending register (newest
// wins) and applied when the transaction completes. The returned instruction
// is then thrown away because it belongs to the wrong path.
module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic [31:0] br_base,
    input  logic [31:0] br_offset,
    input  logic [25:0] jmp_index,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic        flush
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_flush;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic        w_redirect;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_redir_target;
    logic [31:0] w_seq_pc;

    logic        w_req;
    logic        w_apply;
    logic [31:0] w_apply_pc;
    logic        w_complete;
    logic        w_latch_pend;
    logic        w_clear_pend;

    // Target arithmetic; all sums wrap modulo 2^32.
    assign w_redirect     = br_taken | jmp;
    assign w_br_target    = br_base + (br_offset << 2);
    assign w_jmp_target   = {br_base[31:28], jmp_index, 2'b00};
    assign w_redir_target = br_taken ? w_br_target : w_jmp_target;
    assign w_seq_pc       = r_pc + 32'd4;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (!w_redirect && !stall && !imem_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output and datapath-control decode for the current state.
    always_comb begin
        w_req        = 1'b0;
        w_apply      = 1'b0;
        w_apply_pc   = w_redir_target;
        w_complete   = 1'b0;
        w_latch_pend = 1'b0;
        w_clear_pend = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_redirect) begin
                    // Redirect overrides stall and suppresses this cycle's fetch.
                    w_apply = 1'b1;
                end else if (!stall) begin
                    w_req      = 1'b1;
                    w_complete = imem_ready;
                end
            end
            S_WAIT: begin
                // Request stays up regardless of stall until memory completes.
                w_req = 1'b1;
                if (imem_ready) begin
                    w_clear_pend = 1'b1;
                    if (w_redirect) begin
                        w_apply = 1'b1;
                    end else if (r_pend_valid) begin
                        w_apply    = 1'b1;
                        w_apply_pc = r_pend_pc;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_latch_pend = 1'b1;
                end
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // PC, fetch-result, flush and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_if_pc      <= 32'h0000_0000;
            r_if_valid   <= 1'b0;
            r_flush      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'h0000_0000;
        end else begin
            r_flush <= w_apply;
            if (w_apply) begin
                r_pc       <= w_apply_pc;
                r_if_valid <= 1'b0;
            end else if (w_complete) begin
                r_pc       <= w_seq_pc;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
            end
            if (w_latch_pend) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= w_redir_target;
            end else if (w_clear_pend) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Reset masks the combinational request and the flush pulse immediately.
    assign imem_req  = w_req & ~rst;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign flush     = r_flush & ~rst;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Testbench for branch_pc_ctrl: directed vector table plus randomized
// stimulus against a behavioural model of the fetch/redirect rules.
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic        jmp;
    logic [31:0] br_base;
    logic [31:0] br_offset;
    logic [25:0] jmp_index;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .jmp        (jmp),
        .br_base    (br_base),
        .br_offset  (br_offset),
        .jmp_index  (jmp_index),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .flush      (flush)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        jmp;
        logic [31:0] base;
        logic [31:0] off;
        logic [25:0] idx;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ifpc;
        logic        e_fl;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic s, logic b, logic j, logic [31:0] base,
                                logic [31:0] off, logic [25:0] idx, logic rdy,
                                logic e_req, logic [31:0] e_addr, logic e_v,
                                logic [31:0] e_ifpc, logic e_fl);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.jmp = j;
        v.base = base; v.off = off; v.idx = idx; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_ifpc = e_ifpc; v.e_fl = e_fl;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic e_req, logic [31:0] e_addr, logic e_v,
                         logic [31:0] e_ifpc, logic e_fl);
        n_tests++;
        if (imem_req !== e_req || imem_addr !== e_addr || if_valid !== e_v ||
            if_pc !== e_ifpc || flush !== e_fl) begin
            n_fail++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b if_pc=%h flush=%0b, expected req=%0b addr=%h valid=%0b if_pc=%h flush=%0b",
                     name, imem_req, imem_addr, if_valid, if_pc, flush,
                     e_req, e_addr, e_v, e_ifpc, e_fl);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic        m_v;
    logic        m_fl;
    logic        m_idle;
    logic        m_busy;
    logic [31:0] m_pend[$];

    function automatic logic [31:0] model_target();
        if (br_taken)
            return br_base + br_offset * 32'd4;
        return (br_base & 32'hF000_0000) | ({6'b0, jmp_index} * 32'd4);
    endfunction

    function automatic logic model_req();
        if (rst || m_idle) return 1'b0;
        if (m_busy) return 1'b1;
        return !(br_taken || jmp) && !stall;
    endfunction

    task automatic model_edge();
        logic        redir;
        logic        applied;
        logic [31:0] tgt;
        redir   = br_taken || jmp;
        tgt     = model_target();
        applied = 1'b0;
        if (rst) begin
            m_pc = 32'h0; m_if_pc = 32'h0; m_v = 1'b0;
            m_idle = 1'b1; m_busy = 1'b0; m_pend.delete();
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_busy) begin
            if (imem_ready) begin
                if (redir) begin
                    m_pc = tgt; m_v = 1'b0; applied = 1'b1;
                end else if (m_pend.size() > 0) begin
                    m_pc = m_pend[$]; m_v = 1'b0; applied = 1'b1;
                end else begin
                    m_if_pc = m_pc; m_pc = m_pc + 32'd4; m_v = 1'b1;
                end
                m_busy = 1'b0;
                m_pend.delete();
            end else if (redir) begin
                m_pend.push_back(tgt);
            end
        end else begin
            if (redir) begin
                m_pc = tgt; m_v = 1'b0; applied = 1'b1;
            end else if (!stall) begin
                if (imem_ready) begin
                    m_if_pc = m_pc; m_pc = m_pc + 32'd4; m_v = 1'b1;
                end else begin
                    m_busy = 1'b1;
                end
            end
        end
        m_fl = applied;
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; stall = v.stall; br_taken = v.br; jmp = v.jmp;
        br_base = v.base; br_offset = v.off; jmp_index = v.idx; imem_ready = v.rdy;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
        br_base = 32'h0; br_offset = 32'h0; jmp_index = 26'h0; imem_ready = 1'b1;
        m_pc = 32'h0; m_if_pc = 32'h0; m_v = 1'b0; m_fl = 1'b0; m_idle = 1'b1; m_busy = 1'b0;

        //   rst s  b  j  base          off           idx          rdy  req addr          v  if_pc         fl
        // reset and sequential fetch
        add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h0,        0, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h4,        1, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h8,        1, 32'h4,        0);
        // branch backwards to 0xF0
        add(0, 0, 1, 0, 32'h100,      32'hFFFF_FFFC, 26'h0,      1,   0, 32'hC,        1, 32'h8,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'hF0,       0, 32'h8,        1);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'hF4,       1, 32'hF0,       0);
        // jump overrides stall
        add(0, 1, 0, 1, 32'hA000_0000, 32'h0,       26'h40,      1,   0, 32'hF4,       1, 32'hF0,       0);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'hA000_0100, 0, 32'hF0,      1);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'hA000_0100, 0, 32'hF0,      0);
        // redirect while waiting on memory
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'hA000_0100, 0, 32'hF0,      0);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'hA000_0100, 0, 32'hF0,      0);
        add(0, 0, 1, 0, 32'h100,      32'h40,       26'h0,       0,   1, 32'hA000_0100, 0, 32'hF0,      0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'hA000_0100, 0, 32'hF0,      0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'hA000_0100, 0, 32'hF0,      0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h200,      0, 32'hF0,       1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h204,      1, 32'h200,      0);
        // last pending redirect wins
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'h208,      1, 32'h204,      0);
        add(0, 0, 0, 1, 32'h0,        32'h0,        26'h10,      0,   1, 32'h208,      1, 32'h204,      0);
        add(0, 0, 1, 0, 32'h1000,     32'h1,        26'h0,       0,   1, 32'h208,      1, 32'h204,      0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h208,      1, 32'h204,      0);
        // redirect coinciding with completion, then back-to-back redirects
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'h1004,     0, 32'h204,      1);
        add(0, 0, 1, 0, 32'h2000,     32'h2,        26'h0,       1,   1, 32'h1004,     0, 32'h204,      0);
        add(0, 0, 0, 1, 32'h3000_0000, 32'h0,       26'h3,       1,   0, 32'h2008,     0, 32'h204,      1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h3000_000C, 0, 32'h204,     1);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'h3000_0010, 1, 32'h3000_000C, 0);
        // sequential wrap at the top of the address space
        add(0, 0, 0, 1, 32'hF000_0000, 32'h0,       26'h3FF_FFFF, 1,  0, 32'h3000_0010, 1, 32'h3000_000C, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'hFFFF_FFFC, 0, 32'h3000_000C, 1);
        add(0, 1, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'h0,        1, 32'hFFFF_FFFC, 0);
        // branch beats jump; offset bits shifted out and sum wraps
        add(0, 1, 1, 1, 32'hFFFF_FFF0, 32'h4000_0005, 26'h55,    1,   0, 32'h0,        1, 32'hFFFF_FFFC, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h4,        0, 32'hFFFF_FFFC, 1);
        // reset while waiting with a pending redirect
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   1, 32'h8,        1, 32'h4,        0);
        add(0, 0, 1, 0, 32'h500,      32'h0,        26'h0,       0,   1, 32'h8,        1, 32'h4,        0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        26'h0,       0,   0, 32'h8,        1, 32'h4,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   0, 32'h0,        0, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h0,        0, 32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        26'h0,       1,   1, 32'h4,        1, 32'h0,        0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
                  tbl[i].e_ifpc, tbl[i].e_fl);
            @(posedge clk);
            #1;
        end

        // Randomized run against the model, starting from a reset cycle.
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; imem_ready = 1'b1;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            jmp        = ($urandom_range(0, 7) == 0);
            br_base    = $urandom;
            br_offset  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            jmp_index  = 26'($urandom);
            imem_ready = ($urandom_range(0, 9) < 6);
            #1;
            check($sformatf("rand%0d", c), model_req(), m_pc, m_v, m_if_pc, rst ? 1'b0 : m_fl);
            model_edge();
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pc_ctrl.md
BRANCH_PC_CTRL -- requirements
Module: branch_pc_ctrl

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, fetch address loaded by reset.
REQ-002 SHALL provide port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL provide port: stall  in  1  hazard hold from decode; blocks issue of a new fetch.
REQ-005 SHALL provide port: br_taken  in  1  EX-stage branch resolved taken.
REQ-006 SHALL provide port: jmp  in  1  EX-stage jump.
REQ-007 SHALL provide port: br_base  in  32  PC+4 of the redirecting instruction.
REQ-008 SHALL provide port: br_offset  in  32  sign-extended branch immediate, in words.
REQ-009 SHALL provide port: jmp_index  in  26  jump instruction index field.
REQ-010 SHALL provide port: imem_ready  in  1  instruction memory accepts/completes the current request.
REQ-011 SHALL provide port: imem_req  out  1  fetch request.
REQ-012 SHALL provide port: imem_addr  out  32  fetch address (equals pc).
REQ-013 SHALL provide port: if_valid  out  1  fetched instruction at if_pc is valid for decode.
REQ-014 SHALL provide port: if_pc  out  32  address of the last completed fetch.
REQ-015 SHALL provide port: flush  out  1  one-cycle pulse that kills the instruction in decode.

Function
REQ-016 SHALL hold a 32-bit pc register; imem_addr = pc combinationally.
REQ-017 SHALL compute targets mod 2^32: branch = br_base + (br_offset << 2), bits shifted out of bit 31 discarded; jump = {br_base[31:28], jmp_index, 2'b00}; sequential = pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 SHALL treat a redirect as br_taken | jmp; if both are high, br_taken wins.
REQ-019 SHALL implement the states IDLE, FETCH, and WAIT, with IDLE -> FETCH unconditionally after one cycle and imem_req = 0 in IDLE.
REQ-020 SHALL, in FETCH with stall = 0 and no redirect, drive imem_req = 1; on imem_ready = 1, load pc <= pc + 4, register if_pc <= pc and if_valid <= 1, and remain in FETCH; on imem_ready = 0, go to WAIT.
REQ-021 SHALL, in FETCH with stall = 1 and no redirect, drive imem_req = 0 and hold pc, if_pc and if_valid unchanged.
REQ-022 SHALL hold imem_req = 1 and imem_addr constant in WAIT until imem_ready = 1, regardless of stall; on completion it SHALL behave as in REQ-020 and return to FETCH.
REQ-023 SHALL, on a redirect in FETCH, drive imem_req = 0 that cycle, load pc <= target, set if_valid <= 0, pulse flush = 1 for the next cycle only, and remain in FETCH; a redirect overrides stall.
REQ-024 SHALL, on a redirect in WAIT, latch the target into a pending register and keep the request alive; when imem_ready = 1 it SHALL discard the returned instruction (if_valid <= 0), load pc <= pending target, pulse flush, clear pending, and return to FETCH.
REQ-025 SHALL let a later redirect in WAIT overwrite an earlier pending target (last-wins).
REQ-026 SHALL, on a redirect coinciding with imem_ready = 1 in WAIT, use the new target immediately and discard the returned instruction.
REQ-027 SHALL drive flush high for exactly one cycle per applied redirect; back-to-back redirects SHALL produce back-to-back pulses.

Reset
REQ-028 SHALL, while rst = 1, set pc = RESET_PC, state = IDLE, imem_req = 0, if_valid = 0, if_pc = 0, flush = 0, and clear the pending target.
REQ-029 SHALL give reset priority over every other input, including during WAIT, where the outstanding request is abandoned and the pending redirect is dropped.

Verification
REQ-030 SHALL be covered by a sequential-fetch scenario: reset, imem_ready = 1 constant -> imem_addr 0, 0, 4, 8 on cycles 1-4 after reset release, with if_valid rising one cycle after the first request.
REQ-031 SHALL be covered by a branch scenario: br_taken with br_base = 32'h0000_0100 and br_offset = 32'hFFFF_FFFC -> next imem_addr = 32'h0000_00F0, flush pulsed exactly one cycle, and if_valid = 0 that cycle.
REQ-032 SHALL be covered by a jump-wins-over-stall scenario: jmp with br_base = 32'hA000_0000, jmp_index = 26'h000_0040, and stall = 1 -> pc = 32'hA000_0100.
REQ-033 SHALL be covered by a redirect-in-WAIT scenario: imem_ready held 0 for 3 cycles with a branch to 32'h200 in cycle 2 -> imem_addr unchanged until ready; then the instruction is discarded, pc = 32'h200, and one flush pulse occurs.
REQ-034 SHALL be covered by a wrap scenario: pc = 32'hFFFF_FFFC with a completed fetch -> pc = 32'h0000_0000.
REQ-035 SHALL be covered by a reset-mid-WAIT scenario: rst asserted with a pending redirect -> pc = RESET_PC, imem_req = 0, and no flush after release.
